// File: rtl/wbu_pkg.sv
// Writeback-stage configuration shared with the decode stage.
// Holds the source-select width and the writeback source codes.
// Pure declarations; no logic, no latency, no flow control.
package wbu_pkg;

    // Width of the decoded writeback source select field
    localparam int ARGS_WIDTH = 8;

    // Writeback source codes; decode emits these, writeback consumes them
    localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_X   = 8'd0;
    localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_ALU = 8'd1;
    localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_MEM = 8'd2;
    localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_PC  = 8'd3;

    // A source code is usable only if it names a real data source;
    // REG_WR_SRC_X and any undefined code mean "no writeback".
    function automatic logic src_is_valid(input logic [ARGS_WIDTH-1:0] src);
        return (src == REG_WR_SRC_ALU) ||
               (src == REG_WR_SRC_MEM) ||
               (src == REG_WR_SRC_PC);
    endfunction

endpackage : wbu_pkg

// File: rtl/wbu_src_mux.sv
// Writeback data source mux: ALU result, load result or PC+4 (link value).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module wbu_src_mux
    import wbu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [ARGS_WIDTH-1:0] i_src,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_exu_res,
    input  logic [DATA_WIDTH-1:0] i_ram_res,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_src_vld
);

    // Link value for jumps; the add wraps naturally at DATA_WIDTH bits
    logic [DATA_WIDTH-1:0] pc_link;
    assign pc_link = i_pc + DATA_WIDTH'(4);

    // Select write data; unknown codes yield zero data and flag invalid
    always_comb begin
        o_data    = '0;
        o_src_vld = 1'b0;
        case (i_src)
            REG_WR_SRC_ALU: begin
                o_data    = i_exu_res;
                o_src_vld = 1'b1;
            end
            REG_WR_SRC_MEM: begin
                o_data    = i_ram_res;
                o_src_vld = 1'b1;
            end
            REG_WR_SRC_PC: begin
                o_data    = pc_link;
                o_src_vld = 1'b1;
            end
            default: begin
                o_data    = '0;
                o_src_vld = 1'b0;
            end
        endcase
    end

endmodule : wbu_src_mux

// File: rtl/wbu.sv
// Writeback unit: picks GPR write data/enable and registers it for the regfile.
// Latency: exactly 1 cycle from a sampled i_sys_ready to o_sys_valid.
// Backpressure: none; downstream always accepts, throughput 1 result per cycle.
module wbu
    import wbu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sys_ready,
    output logic                  o_sys_valid,
    input  logic                  i_idu_ctr_reg_wr_en,
    input  logic [ARGS_WIDTH-1:0] i_idu_ctr_reg_wr_src,
    input  logic [DATA_WIDTH-1:0] i_ifu_pc,
    input  logic [DATA_WIDTH-1:0] i_exu_res,
    input  logic [DATA_WIDTH-1:0] i_ram_res,
    input  logic [4:0]            i_gpr_wr_id,
    output logic                  o_wbu_gpr_wr_en,
    output logic [4:0]            o_wbu_gpr_wr_id,
    output logic [DATA_WIDTH-1:0] o_wbu_gpr_wr_data
);

    logic [DATA_WIDTH-1:0] mux_data;
    logic                  mux_src_vld;
    logic                  wr_en_eff;

    logic                  vld_q,  vld_d;
    logic                  en_q,   en_d;
    logic [4:0]            id_q,   id_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    wbu_src_mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_src_mux (
        .i_src     (i_idu_ctr_reg_wr_src),
        .i_pc      (i_ifu_pc),
        .i_exu_res (i_exu_res),
        .i_ram_res (i_ram_res),
        .o_data    (mux_data),
        .o_src_vld (mux_src_vld)
    );

    // x0 is hardwired zero, so a write to it is dropped here rather than in the regfile
    assign wr_en_eff = i_idu_ctr_reg_wr_en && (i_gpr_wr_id != 5'd0) && mux_src_vld;

    // Next state: capture a new result when ready, otherwise hold id/data and drop the strobe
    always_comb begin
        vld_d  = 1'b0;
        en_d   = 1'b0;
        id_d   = id_q;
        data_d = data_q;
        if (i_sys_ready) begin
            vld_d  = 1'b1;
            en_d   = wr_en_eff;
            id_d   = i_gpr_wr_id;
            data_d = mux_data;
        end
    end

    // Output register; reset wins over a concurrent ready and discards it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_q  <= 1'b0;
            en_q   <= 1'b0;
            id_q   <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            en_q   <= en_d;
            id_q   <= id_d;
            data_q <= data_d;
        end
    end

    assign o_sys_valid       = vld_q;
    assign o_wbu_gpr_wr_en   = en_q;
    assign o_wbu_gpr_wr_id   = id_q;
    assign o_wbu_gpr_wr_data = data_q;

endmodule : wbu

// File: tb/tb_wbu.sv
// Bench for wbu: directed scenarios with literal expectations plus a random run,
// all outputs compared every cycle against a behavioural model.
module tb_wbu;
    import wbu_pkg::*;

    localparam int DW = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  ready;
    logic                  wr_en;
    logic [ARGS_WIDTH-1:0] src;
    logic [DW-1:0]         pc, exu, ram;
    logic [4:0]            id;
    logic                  o_vld, o_en;
    logic [4:0]            o_id;
    logic [DW-1:0]         o_data;

    int checks   = 0;
    int failures = 0;

    // Model state: what the outputs must be after the latest edge
    logic          m_vld, m_en;
    logic [4:0]    m_id;
    logic [DW-1:0] m_data;
    bit            model_ok = 0;

    always #5 clk = ~clk;

    wbu #(.DATA_WIDTH(DW)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_sys_ready         (ready),
        .o_sys_valid         (o_vld),
        .i_idu_ctr_reg_wr_en (wr_en),
        .i_idu_ctr_reg_wr_src(src),
        .i_ifu_pc            (pc),
        .i_exu_res           (exu),
        .i_ram_res           (ram),
        .i_gpr_wr_id         (id),
        .o_wbu_gpr_wr_en     (o_en),
        .o_wbu_gpr_wr_id     (o_id),
        .o_wbu_gpr_wr_data   (o_data)
    );

    // Behavioural model: one writeback result per ready cycle, arithmetic from the rules
    always @(posedge clk) begin
        if (rst) begin
            m_vld = 0; m_en = 0; m_id = 0; m_data = 0;
            model_ok = 1;
        end else if (ready) begin
            longint unsigned link;
            link   = (longint'(pc) + 4) % (64'd1 << DW);
            m_vld  = 1;
            m_id   = id;
            if (src == 1)      m_data = exu;
            else if (src == 2) m_data = ram;
            else if (src == 3) m_data = link[DW-1:0];
            else               m_data = 0;
            m_en   = wr_en && (id != 0) && (src >= 1 && src <= 3);
        end else begin
            m_vld = 0;
            m_en  = 0;
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (model_ok) begin
            check("cmp_valid", DW'(o_vld), DW'(m_vld));
            check("cmp_wr_en", DW'(o_en),  DW'(m_en));
            check("cmp_wr_id", DW'(o_id),  DW'(m_id));
            check("cmp_data",  o_data,     m_data);
            check("en_implies_valid", DW'(o_en & ~o_vld), '0);
        end
    end

    // Drive one set of inputs just after an edge, then wait until the result is visible
    task automatic apply(input logic r, input logic rdy, input logic en,
                         input logic [ARGS_WIDTH-1:0] s, input logic [DW-1:0] p,
                         input logic [DW-1:0] e, input logic [DW-1:0] m, input logic [4:0] i);
        rst = r; ready = rdy; wr_en = en; src = s; pc = p; exu = e; ram = m; id = i;
        @(posedge clk); #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic en,
                              input logic [4:0] i, input logic [DW-1:0] d);
        check({tag, "_valid"}, DW'(o_vld), DW'(v));
        check({tag, "_wr_en"}, DW'(o_en),  DW'(en));
        check({tag, "_wr_id"}, DW'(o_id),  DW'(i));
        check({tag, "_data"},  o_data,     d);
    endtask

    initial begin
        rst = 1; ready = 1; wr_en = 1; src = REG_WR_SRC_ALU;
        pc = '0; exu = 32'h1234; ram = '0; id = 5'd9;
        @(posedge clk); #1;
        apply(1, 1, 1, REG_WR_SRC_ALU, 0, 32'hABCD, 0, 5'd9);
        expect_out("reset", 0, 0, 0, 0);

        // Scenario 1/2: ALU, MEM, PC sources
        apply(0, 1, 1, REG_WR_SRC_ALU, 32'h8000_0000, 1, 2, 1);
        expect_out("s1_alu", 1, 1, 1, 32'h1);
        apply(0, 1, 1, REG_WR_SRC_MEM, 32'h8000_0000, 1, 2, 1);
        expect_out("s2_mem", 1, 1, 1, 32'h2);
        apply(0, 1, 1, REG_WR_SRC_PC, 32'h8000_0000, 1, 2, 1);
        expect_out("s2_pc", 1, 1, 1, 32'h8000_0004);

        // Scenario 3: x0 destination, then invalid source
        apply(0, 1, 1, REG_WR_SRC_ALU, 32'h8000_0000, 1, 2, 0);
        expect_out("s3_x0", 1, 0, 0, 32'h1);
        apply(0, 1, 1, REG_WR_SRC_X, 32'h8000_0000, 1, 2, 1);
        expect_out("s3_badsrc", 1, 0, 1, 32'h0);

        // Scenario 4: PC+4 wraps
        apply(0, 1, 1, REG_WR_SRC_PC, 32'hFFFF_FFFC, 1, 2, 5);
        expect_out("s4_wrap", 1, 1, 5, 32'h0);

        // Scenario 5: ready 1,0,1 -- gap holds id/data
        apply(0, 1, 1, REG_WR_SRC_ALU, 0, 32'h55, 0, 3);
        expect_out("s5_a", 1, 1, 3, 32'h55);
        apply(0, 0, 1, REG_WR_SRC_ALU, 0, 32'h99, 0, 7);
        expect_out("s5_gap", 0, 0, 3, 32'h55);
        apply(0, 1, 1, REG_WR_SRC_ALU, 0, 32'h99, 0, 7);
        expect_out("s5_b", 1, 1, 7, 32'h99);

        // Scenario 6: reset wins over ready, then results resume
        apply(1, 1, 1, REG_WR_SRC_MEM, 0, 0, 32'h77, 4);
        expect_out("s6_rst", 0, 0, 0, 0);
        apply(0, 1, 1, REG_WR_SRC_MEM, 0, 0, 32'h77, 4);
        expect_out("s6_resume", 1, 1, 4, 32'h77);

        // Random traffic including invalid source codes, x0 and occasional reset
        for (int n = 0; n < 400; n++) begin
            logic [ARGS_WIDTH-1:0] s;
            case ($urandom_range(0, 5))
                0: s = REG_WR_SRC_X;
                1: s = ARGS_WIDTH'($urandom_range(4, 255));
                2: s = REG_WR_SRC_ALU;
                3: s = REG_WR_SRC_MEM;
                default: s = REG_WR_SRC_PC;
            endcase
            apply(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1, s,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom,
                  $urandom, $urandom,
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wbu
